uart_tx_fsm: RTL

UART transmitter for the low-power communication system. It takes a parallel byte, frames it with a start bit, an optional parity bit and a stop bit, and drives it serially LSB-first on `TX_OUT`. Each bit is held for a programmable number of clock cycles. It pairs with the UART receiver on the opposite link end and shares its frame format: start(0), 8 data bits, optional even/odd parity, stop(1).

---
 rtl/uart_tx_fsm.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fsm
//  Description : UART transmitter. Frames a parallel word as
//                start(0) / DATA_WIDTH data bits LSB-first / optional
//                even-odd parity / stop(1), each bit held for a
//                programmable number of clock cycles. Supports
//                back-to-back frames by accepting a new request in the
//                last stop-bit cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [DATA_WIDTH-1:0]     P_Data,
    input  logic                      Data_valid,
    input  logic                      Parity_EN,
    input  logic                      Parity_type,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int c_IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                    r_state;
    logic [PRESCALE_WIDTH-1:0] r_cnt;      // cycles spent in current bit
    logic [PRESCALE_WIDTH-1:0] r_pm1;      // latched bit period minus one
    logic [c_IDX_W-1:0]        r_idx;      // data bit currently on the line
    logic [DATA_WIDTH-1:0]     r_shift;    // remaining data bits, LSB next
    logic                      r_par_en;
    logic                      r_par_bit;

    logic                      w_last;
    logic                      w_accept;
    logic [PRESCALE_WIDTH-1:0] w_pm1_in;
    logic [DATA_WIDTH-1:0]     w_shift_nxt;

    // Bit boundary, request acceptance and incoming period decode
    always_comb begin
        w_last      = (r_cnt == r_pm1);
        w_accept    = Data_valid &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_last));
        // A programmed prescale of 0 behaves as 1 cycle per bit
        w_pm1_in    = (Prescale == '0) ? '0 : (Prescale - PRESCALE_WIDTH'(1));
        w_shift_nxt = r_shift >> 1;
    end

    // Frame sequencer with registered serial line and busy flag
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pm1     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            TX_OUT    <= 1'b1;
            Busy      <= 1'b0;
        end else if (w_accept) begin
            // Shadow the request so later input changes cannot disturb the frame
            r_state   <= S_START;
            r_cnt     <= '0;
            r_pm1     <= w_pm1_in;
            r_idx     <= '0;
            r_shift   <= P_Data;
            r_par_en  <= Parity_EN;
            r_par_bit <= (^P_Data) ^ Parity_type;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                end
                S_START: begin
                    if (w_last) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                        TX_OUT  <= r_shift[0];
                    end else begin
                        r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_idx == c_LAST_IDX) begin
                            r_idx <= '0;
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                TX_OUT  <= r_par_bit;
                            end else begin
                                r_state <= S_STOP;
                                TX_OUT  <= 1'b1;
                            end
                        end else begin
                            r_idx   <= r_idx + c_IDX_W'(1);
                            r_shift <= w_shift_nxt;
                            TX_OUT  <= w_shift_nxt[0];
                        end
                    end else begin
                        r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
                    end
                end
                S_PARITY: begin
                    if (w_last) begin
                        r_state <= S_STOP;
                        r_cnt   <= '0;
                        TX_OUT  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
                    end
                end
                S_STOP: begin
                    // An accept in the final stop cycle is handled above
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        TX_OUT  <= 1'b1;
                        Busy    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    TX_OUT  <= 1'b1;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
